// File: rtl/fdiv_iter.sv
// Iterative radix-2 restoring divider producing an unrounded significand
// with guard/round/sticky, wide signed exponent and class flags for fnorm.
module fdiv_iter #(
    parameter int FW  = 23,
    parameter int EW  = 8,
    parameter int FW1 = FW + 3,
    parameter int EW1 = EW + 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [EW+FW:0] opA,
    input  logic [EW+FW:0] opB,
    input  logic [2:0]     rm_i,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW1-1:0] exponentQ,
    output logic [FW1:0]   significantQ,
    output logic           signQ,
    output logic           infQ,
    output logic           nanQ,
    output logic           zeroQ,
    output logic           dzQ,
    output logic [2:0]     rmQ
);

    localparam int MW  = FW + 1;
    localparam int RW  = FW + 3;
    localparam int LZW = $clog2(MW + 1);
    localparam int CW  = $clog2(FW + 3);

    localparam logic [EW1-1:0] BIAS = EW1'((2 ** (EW - 1)) - 1);
    localparam logic [CW-1:0]  LAST = CW'(FW + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     state;
    logic [EW+FW:0] a_q, b_q;
    logic [2:0]     rm_q;
    logic [RW-1:0]  rem;
    logic [MW-1:0]  mb;
    logic [RW-1:0]  q;
    logic [CW-1:0]  cnt;
    logic [EW1-1:0] e_q;

    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] m);
        lzc = LZW'(MW);
        for (int i = 0; i < MW; i++)
            if (m[i]) lzc = LZW'(MW - 1 - i);
    endfunction

    logic          sa, sb;
    logic [EW-1:0] ea, eb;
    logic [FW-1:0] fa, fb;
    logic          a_zf, b_zf, a_max, b_max;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic          c_nan, c_inf, c_zero, c_dz, special;
    logic [MW-1:0] ma_raw, mb_raw, ma, mb_n;
    logic [LZW-1:0] lza, lzb;
    logic [EW1-1:0] exa, exb, exp_n;
    logic          adj;
    logic [RW-1:0] dividend;

    always_comb begin
        sa = a_q[EW+FW];
        sb = b_q[EW+FW];
        ea = a_q[EW+FW-1:FW];
        eb = b_q[EW+FW-1:FW];
        fa = a_q[FW-1:0];
        fb = b_q[FW-1:0];
        a_zf  = ~|ea;
        b_zf  = ~|eb;
        a_max = &ea;
        b_max = &eb;
        a_nan  = a_max & (|fa);
        b_nan  = b_max & (|fb);
        a_inf  = a_max & ~(|fa);
        b_inf  = b_max & ~(|fb);
        a_zero = a_zf & ~(|fa);
        b_zero = b_zf & ~(|fb);
        c_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
        c_inf  = ~c_nan & (a_inf | b_zero);
        c_zero = ~c_nan & ~c_inf & (a_zero | b_inf);
        c_dz   = ~c_nan & b_zero & ~a_inf;
        special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        // subnormals: unit exponent, no hidden bit, then normalize
        ma_raw = {~a_zf, fa};
        mb_raw = {~b_zf, fb};
        lza  = lzc(ma_raw);
        lzb  = lzc(mb_raw);
        ma   = ma_raw << lza;
        mb_n = mb_raw << lzb;
        exa = {{(EW1-EW){1'b0}}, (a_zf ? EW'(1) : ea)}
            - {{(EW1-LZW){1'b0}}, lza};
        exb = {{(EW1-EW){1'b0}}, (b_zf ? EW'(1) : eb)}
            - {{(EW1-LZW){1'b0}}, lzb};
        adj = ma < mb_n;
        dividend = adj ? {1'b0, ma, 1'b0} : {2'b0, ma};
        exp_n = exa - exb + BIAS - {{(EW1-1){1'b0}}, adj};
    end

    logic          ge;
    logic [RW-1:0] rem_sub;
    logic [RW-1:0] q_nx;

    always_comb begin
        ge      = rem >= {2'b0, mb};
        rem_sub = ge ? rem - {2'b0, mb} : rem;
        q_nx    = q;
        q_nx[LAST - cnt] = ge;
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state        <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            rm_q         <= '0;
            rem          <= '0;
            mb           <= '0;
            q            <= '0;
            cnt          <= '0;
            e_q          <= '0;
            exponentQ    <= '0;
            significantQ <= '0;
            signQ        <= 1'b0;
            infQ         <= 1'b0;
            nanQ         <= 1'b0;
            zeroQ        <= 1'b0;
            dzQ          <= 1'b0;
            rmQ          <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= opA;
                        b_q   <= opB;
                        rm_q  <= rm_i;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (special) begin
                        exponentQ    <= '0;
                        significantQ <= '0;
                        signQ        <= sa ^ sb;
                        infQ         <= c_inf;
                        nanQ         <= c_nan;
                        zeroQ        <= c_zero;
                        dzQ          <= c_dz;
                        rmQ          <= rm_q;
                        state        <= S_DONE;
                    end else begin
                        rem   <= dividend;
                        mb    <= mb_n;
                        e_q   <= exp_n;
                        q     <= '0;
                        cnt   <= '0;
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem <= rem_sub << 1;
                    q   <= q_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        significantQ <= {q_nx, |rem_sub};
                        exponentQ    <= e_q;
                        signQ        <= a_q[EW+FW] ^ b_q[EW+FW];
                        infQ         <= 1'b0;
                        nanQ         <= 1'b0;
                        zeroQ        <= 1'b0;
                        dzQ          <= 1'b0;
                        rmQ          <= rm_q;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
